// File: rtl/turbidity_uart_rx_if.sv
// Signal bundle between the ESP32 turbidity receiver and the irrigation controller.
// The slave side is the receiver; the master side is the controller and the serial line.
interface turbidity_uart_rx_if;
  logic        enable_esp;
  logic        uart_rx;
  logic [11:0] turbidez;
  logic        ready_from_esp;
  logic        frame_error;
  logic        timeout;

  modport master (
    output enable_esp,
    output uart_rx,
    input  turbidez,
    input  ready_from_esp,
    input  frame_error,
    input  timeout
  );

  modport slave (
    input  enable_esp,
    input  uart_rx,
    output turbidez,
    output ready_from_esp,
    output frame_error,
    output timeout
  );
endinterface

// File: rtl/turbidity_uart_rx.sv
// 8N1 UART receiver, 4-byte frame parser (A5 HI LO CHK) and sample averager that
// answers controller requests with a held result or a fail-safe timeout result.
module turbidity_uart_rx #(
  parameter int CLK_HZ         = 25000000,
  parameter int BAUD           = 115200,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 25000000
) (
  input  logic clk,
  input  logic reset,
  turbidity_uart_rx_if.slave bus
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam int NUM_AVG      = 1 << AVG_LOG2;
  localparam int ACC_W        = 12 + AVG_LOG2;
  localparam int CNT_W        = AVG_LOG2 + 1;
  localparam int TMR_W        = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_SYNC, P_HI, P_LO, P_CHK} p_state_t;

  // Line synchroniser; resets to the idle (high) level so reset never looks like a start bit.
  logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

  rx_state_t            rx_state_reg, rx_state_next;
  logic [BIT_CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
  logic [2:0]           bit_idx_reg, bit_idx_next;
  logic [7:0]           shift_reg, shift_next;
  logic                 byte_valid_reg, byte_valid_next;
  logic                 stop_err;

  p_state_t    p_state_reg, p_state_next;
  logic [3:0]  hi_reg, hi_next;
  logic [7:0]  lo_reg, lo_next;
  logic [11:0] sample_reg, sample_next;
  logic        sample_valid_reg, sample_valid_next;
  logic        parse_err;

  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] count_reg;
  logic [TMR_W-1:0] timer_reg;
  logic [11:0]      turbidez_reg;
  logic             ready_reg, timeout_reg, frame_error_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= bus.uart_rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_reg   <= RX_IDLE;
      clk_cnt_reg    <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      byte_valid_reg <= 1'b0;
    end else begin
      rx_state_reg   <= rx_state_next;
      clk_cnt_reg    <= clk_cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      byte_valid_reg <= byte_valid_next;
    end
  end

  always_comb begin
    rx_state_next   = rx_state_reg;
    clk_cnt_next    = clk_cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    byte_valid_next = 1'b0;
    stop_err        = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        clk_cnt_next = '0;
        bit_idx_next = '0;
        if (rx_prev_reg && !rx_sync_reg) rx_state_next = RX_START;
      end
      RX_START: begin
        if (clk_cnt_reg == BIT_CNT_W'(HALF_BIT - 1)) begin
          clk_cnt_next  = '0;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + BIT_CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (clk_cnt_reg == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_next = '0;
          shift_next   = {rx_sync_reg, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) rx_state_next = RX_STOP;
          else                     bit_idx_next  = bit_idx_reg + 3'd1;
        end else begin
          clk_cnt_next = clk_cnt_reg + BIT_CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (clk_cnt_reg == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_next    = '0;
          rx_state_next   = RX_IDLE;
          byte_valid_next = rx_sync_reg;
          stop_err        = !rx_sync_reg;
        end else begin
          clk_cnt_next = clk_cnt_reg + BIT_CNT_W'(1);
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_state_reg      <= P_SYNC;
      hi_reg           <= '0;
      lo_reg           <= '0;
      sample_reg       <= '0;
      sample_valid_reg <= 1'b0;
    end else begin
      p_state_reg      <= p_state_next;
      hi_reg           <= hi_next;
      lo_reg           <= lo_next;
      sample_reg       <= sample_next;
      sample_valid_reg <= sample_valid_next;
    end
  end

  // The received byte is shift_reg itself; it stays stable while byte_valid_reg is high.
  always_comb begin
    p_state_next      = p_state_reg;
    hi_next           = hi_reg;
    lo_next           = lo_reg;
    sample_next       = sample_reg;
    sample_valid_next = 1'b0;
    parse_err         = 1'b0;
    if (!bus.enable_esp) begin
      p_state_next = P_SYNC;
    end else if (byte_valid_reg) begin
      case (p_state_reg)
        P_SYNC: if (shift_reg == 8'hA5) p_state_next = P_HI;
        P_HI: begin
          if (shift_reg[7:4] != 4'h0) begin
            parse_err    = 1'b1;
            p_state_next = P_SYNC;
          end else begin
            hi_next      = shift_reg[3:0];
            p_state_next = P_LO;
          end
        end
        P_LO: begin
          lo_next      = shift_reg;
          p_state_next = P_CHK;
        end
        P_CHK: begin
          p_state_next = P_SYNC;
          if (shift_reg == ({4'h0, hi_reg} ^ lo_reg ^ 8'hA5)) begin
            sample_valid_next = 1'b1;
            sample_next       = {hi_reg, lo_reg};
          end else begin
            parse_err = 1'b1;
          end
        end
        default: p_state_next = P_SYNC;
      endcase
    end
  end

  // Completion is checked before the timer so a finished average beats a same-cycle timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg         <= '0;
      count_reg       <= '0;
      timer_reg       <= '0;
      turbidez_reg    <= '0;
      ready_reg       <= 1'b0;
      timeout_reg     <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      frame_error_reg <= stop_err | parse_err;
      if (!bus.enable_esp) begin
        acc_reg   <= '0;
        count_reg <= '0;
        timer_reg <= '0;
        ready_reg <= 1'b0;
      end else if (ready_reg) begin
        acc_reg   <= '0;
        count_reg <= '0;
        timer_reg <= '0;
      end else if (count_reg == CNT_W'(NUM_AVG)) begin
        turbidez_reg <= 12'(acc_reg >> AVG_LOG2);
        ready_reg    <= 1'b1;
        timeout_reg  <= 1'b0;
        acc_reg      <= '0;
        count_reg    <= '0;
        timer_reg    <= '0;
      end else if (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1)) begin
        turbidez_reg <= '0;
        ready_reg    <= 1'b1;
        timeout_reg  <= 1'b1;
        acc_reg      <= '0;
        count_reg    <= '0;
        timer_reg    <= '0;
      end else begin
        timer_reg <= timer_reg + TMR_W'(1);
        if (sample_valid_reg) begin
          acc_reg   <= acc_reg + ACC_W'(sample_reg);
          count_reg <= count_reg + CNT_W'(1);
        end
      end
    end
  end

  assign bus.turbidez       = turbidez_reg;
  assign bus.ready_from_esp = ready_reg;
  assign bus.frame_error    = frame_error_reg;
  assign bus.timeout        = timeout_reg;
endmodule

// File: tb/tb_turbidity_uart_rx.sv
// Directed bench for turbidity_uart_rx: one UART line shared by a long-timeout DUT
// (averaging tests) and a 1000-cycle-timeout DUT (fail-safe path).
module tb_turbidity_uart_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset;
  logic line;
  int   tests = 0;
  int   failures = 0;
  int   fe_count = 0;

  turbidity_uart_rx_if bus ();
  turbidity_uart_rx_if bus_to ();

  assign bus.uart_rx    = line;
  assign bus_to.uart_rx = line;

  always #5 clk = ~clk;

  turbidity_uart_rx #(.CLK_HZ(1600000), .BAUD(100000), .AVG_LOG2(2), .TIMEOUT_CYCLES(200000))
    dut (.clk(clk), .reset(reset), .bus(bus));

  turbidity_uart_rx #(.CLK_HZ(1600000), .BAUD(100000), .AVG_LOG2(2), .TIMEOUT_CYCLES(1000))
    dut_to (.clk(clk), .reset(reset), .bus(bus_to));

  always @(negedge clk) if (bus.frame_error === 1'b1) fe_count++;

  // All tasks start and finish 1 ns after a rising edge.
  task automatic send_bit(input logic b);
    line = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_frame(input logic [11:0] v);
    logic [7:0] hi, lo;
    hi = {4'h0, v[11:8]};
    lo = v[7:0];
    send_byte(8'hA5, 1'b1);
    send_byte(hi, 1'b1);
    send_byte(lo, 1'b1);
    send_byte(hi ^ lo ^ 8'hA5, 1'b1);
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tests++; if (bus.turbidez !== 12'd0) begin failures++; $display("FAIL reset_turbidez got %0d want 0", bus.turbidez); end
    tests++; if (bus.ready_from_esp !== 1'b0) begin failures++; $display("FAIL reset_ready got %b want 0", bus.ready_from_esp); end
    tests++; if (bus.frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error got %b want 0", bus.frame_error); end
    tests++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got %b want 0", bus.timeout); end
    tests++; if (bus_to.ready_from_esp !== 1'b0) begin failures++; $display("FAIL reset_to_ready got %b want 0", bus_to.ready_from_esp); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_four_frames;
    int fe0;
    fe0 = fe_count;
    bus.enable_esp = 1'b1;
    send_frame(12'd100);
    send_frame(12'd200);
    send_frame(12'd300);
    tests++; if (bus.ready_from_esp !== 1'b0) begin failures++; $display("FAIL avg_early_ready got %b want 0", bus.ready_from_esp); end
    send_frame(12'd400);
    tests++; if (bus.ready_from_esp !== 1'b1) begin failures++; $display("FAIL avg_ready got %b want 1", bus.ready_from_esp); end
    tests++; if (bus.turbidez !== 12'd250) begin failures++; $display("FAIL avg_turbidez got %0d want 250", bus.turbidez); end
    tests++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL avg_timeout got %b want 0", bus.timeout); end
    idle(20);
    tests++; if (bus.ready_from_esp !== 1'b1) begin failures++; $display("FAIL avg_ready_held got %b want 1", bus.ready_from_esp); end
    bus.enable_esp = 1'b0;
    @(posedge clk); #1;
    tests++; if (bus.ready_from_esp !== 1'b0) begin failures++; $display("FAIL avg_ready_clear got %b want 0", bus.ready_from_esp); end
    tests++; if (bus.turbidez !== 12'd250) begin failures++; $display("FAIL avg_turbidez_hold got %0d want 250", bus.turbidez); end
    tests++; if (fe_count - fe0 !== 0) begin failures++; $display("FAIL avg_no_error got %0d want 0", fe_count - fe0); end
    $display("[TB] test_four_frames done");
  endtask

  task automatic test_bad_checksum;
    int fe0;
    idle(10);
    fe0 = fe_count;
    bus.enable_esp = 1'b1;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h64, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) send_frame(12'd12);
    tests++; if (bus.ready_from_esp !== 1'b0) begin failures++; $display("FAIL chk_early_ready got %b want 0", bus.ready_from_esp); end
    send_frame(12'd12);
    tests++; if (bus.ready_from_esp !== 1'b1) begin failures++; $display("FAIL chk_ready got %b want 1", bus.ready_from_esp); end
    tests++; if (bus.turbidez !== 12'd12) begin failures++; $display("FAIL chk_turbidez got %0d want 12", bus.turbidez); end
    tests++; if (fe_count - fe0 !== 1) begin failures++; $display("FAIL chk_error_pulses got %0d want 1", fe_count - fe0); end
    bus.enable_esp = 1'b0;
    idle(10);
    $display("[TB] test_bad_checksum done");
  endtask

  task automatic test_glitch_stop;
    int fe0;
    fe0 = fe_count;
    bus.enable_esp = 1'b1;
    line = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(4 * CPB);
    tests++; if (fe_count - fe0 !== 0) begin failures++; $display("FAIL glitch_error got %0d want 0", fe_count - fe0); end
    send_byte(8'h55, 1'b0);
    idle(2 * CPB);
    tests++; if (fe_count - fe0 !== 1) begin failures++; $display("FAIL stop_error got %0d want 1", fe_count - fe0); end
    send_frame(12'd10);
    send_frame(12'd20);
    send_frame(12'd30);
    send_frame(12'd41);
    tests++; if (bus.ready_from_esp !== 1'b1) begin failures++; $display("FAIL stop_resync_ready got %b want 1", bus.ready_from_esp); end
    tests++; if (bus.turbidez !== 12'd25) begin failures++; $display("FAIL stop_resync_turbidez got %0d want 25", bus.turbidez); end
    tests++; if (fe_count - fe0 !== 1) begin failures++; $display("FAIL stop_total_errors got %0d want 1", fe_count - fe0); end
    bus.enable_esp = 1'b0;
    idle(10);
    $display("[TB] test_glitch_stop done");
  endtask

  task automatic test_timeout;
    bus_to.enable_esp = 1'b1;
    send_frame(12'd500);
    repeat (999 - 4 * 10 * CPB) @(posedge clk);
    #1;
    tests++; if (bus_to.ready_from_esp !== 1'b0) begin failures++; $display("FAIL to_early_ready got %b want 0", bus_to.ready_from_esp); end
    @(posedge clk); #1;
    tests++; if (bus_to.ready_from_esp !== 1'b1) begin failures++; $display("FAIL to_ready got %b want 1", bus_to.ready_from_esp); end
    tests++; if (bus_to.turbidez !== 12'd0) begin failures++; $display("FAIL to_turbidez got %0d want 0", bus_to.turbidez); end
    tests++; if (bus_to.timeout !== 1'b1) begin failures++; $display("FAIL to_flag got %b want 1", bus_to.timeout); end
    bus_to.enable_esp = 1'b0;
    @(posedge clk); #1;
    tests++; if (bus_to.ready_from_esp !== 1'b0) begin failures++; $display("FAIL to_ready_clear got %b want 0", bus_to.ready_from_esp); end
    tests++; if (bus_to.timeout !== 1'b1) begin failures++; $display("FAIL to_flag_hold got %b want 1", bus_to.timeout); end
    $display("[TB] test_timeout done");
  endtask

  task automatic test_gating;
    bus.enable_esp = 1'b0;
    send_frame(12'd77);
    send_frame(12'd77);
    idle(10);
    bus.enable_esp = 1'b1;
    send_frame(12'd8);
    send_frame(12'd8);
    send_frame(12'd8);
    tests++; if (bus.ready_from_esp !== 1'b0) begin failures++; $display("FAIL gate_early_ready got %b want 0", bus.ready_from_esp); end
    send_frame(12'd8);
    tests++; if (bus.ready_from_esp !== 1'b1) begin failures++; $display("FAIL gate_ready got %b want 1", bus.ready_from_esp); end
    tests++; if (bus.turbidez !== 12'd8) begin failures++; $display("FAIL gate_turbidez got %0d want 8", bus.turbidez); end
    $display("[TB] test_gating done");
  endtask

  task automatic test_reset_mid;
    logic [7:0] hi;
    bus.enable_esp = 1'b0;
    idle(10);
    bus.enable_esp = 1'b1;
    send_frame(12'd4000);
    hi = 8'h0F;
    send_byte(8'hA5, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(hi[i]);
    line = hi[4];
    repeat (CPB / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests++; if (bus.turbidez !== 12'd0) begin failures++; $display("FAIL rst_mid_turbidez got %0d want 0", bus.turbidez); end
    tests++; if (bus.ready_from_esp !== 1'b0) begin failures++; $display("FAIL rst_mid_ready got %b want 0", bus.ready_from_esp); end
    tests++; if (bus_to.timeout !== 1'b0) begin failures++; $display("FAIL rst_mid_to_flag got %b want 0", bus_to.timeout); end
    bus.enable_esp = 1'b0;
    line = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(20 * CPB);
    bus.enable_esp = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(12'd4095);
    tests++; if (bus.ready_from_esp !== 1'b1) begin failures++; $display("FAIL rst_after_ready got %b want 1", bus.ready_from_esp); end
    tests++; if (bus.turbidez !== 12'd4095) begin failures++; $display("FAIL rst_after_turbidez got %0d want 4095", bus.turbidez); end
    bus.enable_esp = 1'b0;
    idle(5);
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    reset = 1'b1;
    line = 1'b1;
    bus.enable_esp = 1'b0;
    bus_to.enable_esp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b0;
    idle(10);
    test_four_frames;
    test_bad_checksum;
    test_glitch_stop;
    test_timeout;
    test_gating;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
